// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: byte-framed UART command bridge to a pipelined Wishbone master.
// Ports: rx/tx AXI-stream bytes, Wishbone cyc/stb/we/addr/data/sel/stall/ack, err_count.
module uart_wb_bridge #(
  parameter int ADDR_BYTES  = 3,
  parameter int DATA_BYTES  = 16,
  parameter int RX_TIMEOUT  = 1_000_000,
  parameter int ACK_TIMEOUT = 65_535
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_rx_tdata,
  input  logic                    i_rx_tvalid,
  output logic                    o_rx_tready,
  output logic [7:0]              o_tx_tdata,
  output logic                    o_tx_tvalid,
  input  logic                    i_tx_tready,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [8*ADDR_BYTES-1:0] o_wb_addr,
  output logic [8*DATA_BYTES-1:0] o_wb_data,
  output logic [DATA_BYTES-1:0]   o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [8*DATA_BYTES-1:0] i_wb_data,
  output logic [7:0]              o_err_count
);

  localparam int AW   = 8*ADDR_BYTES;
  localparam int DW   = 8*DATA_BYTES;
  localparam int NMAX = (ADDR_BYTES > DATA_BYTES) ?
                        ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(NMAX+1);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ST_E = 8'h45;
  localparam logic [7:0] ST_K = 8'h4B;
  localparam logic [7:0] ST_T = 8'h54;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, REQ, WAIT_ACK, RESP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [CW-1:0] tx_left;
  logic [31:0]   tmr;
  logic [DW-1:0] tx_sr;

  logic rx_fire, tx_fire;
  logic rx_to, ack_to;
  logic last_a, last_d;
  logic ld_e, ld_ack, ld_t, err_inc;

  assign o_rx_tready = (state == IDLE) ||
                       (state == ADDR) ||
                       (state == DATA);
  assign o_tx_tvalid = (state == RESP);
  assign o_wb_stb    = (state == REQ);
  assign o_wb_cyc    = (state == REQ) ||
                       (state == WAIT_ACK);
  assign o_wb_sel    = '1;
  assign o_tx_tdata  = tx_sr[DW-1 -: 8];

  assign rx_fire = i_rx_tvalid && o_rx_tready;
  assign tx_fire = o_tx_tvalid && i_tx_tready;
  assign rx_to   = (tmr == 32'(RX_TIMEOUT-1));
  assign ack_to  = (tmr == 32'(ACK_TIMEOUT-1));
  assign last_a  = (cnt == CW'(ADDR_BYTES-1));
  assign last_d  = (cnt == CW'(DATA_BYTES-1));

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_e     = 1'b0;
    ld_ack   = 1'b0;
    ld_t     = 1'b0;
    err_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          if (i_rx_tdata == OP_W || i_rx_tdata == OP_R) begin
            state_nx = ADDR;
          end else begin
            state_nx = RESP;
            ld_e     = 1'b1;
            err_inc  = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          if (last_a) state_nx = o_wb_we ? DATA : REQ;
        end else if (rx_to) begin
          state_nx = IDLE;
          err_inc  = 1'b1;
        end
      end
      DATA: begin
        if (rx_fire) begin
          if (last_d) state_nx = REQ;
        end else if (rx_to) begin
          state_nx = IDLE;
          err_inc  = 1'b1;
        end
      end
      REQ: begin
        // an ack seen while still stalled belongs to nobody
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            state_nx = RESP;
            ld_ack   = 1'b1;
          end else begin
            state_nx = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          state_nx = RESP;
          ld_ack   = 1'b1;
        end else if (ack_to) begin
          state_nx = RESP;
          ld_t     = 1'b1;
          err_inc  = 1'b1;
        end
      end
      RESP: begin
        if (tx_fire && tx_left == CW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // one timer serves both the inter-byte and the ack timeout;
  // it restarts on every accepted byte and every state change
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr <= '0;
    end else if (rx_fire || state_nx != state) begin
      tmr <= '0;
    end else if (state == ADDR || state == DATA ||
                 state == WAIT_ACK) begin
      tmr <= tmr + 32'd1;
    end
  end

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      cnt       <= '0;
    end else if (rx_fire) begin
      unique case (state)
        IDLE: begin
          if (i_rx_tdata == OP_W || i_rx_tdata == OP_R) begin
            o_wb_we <= (i_rx_tdata == OP_W);
            cnt     <= '0;
          end
        end
        ADDR: begin
          o_wb_addr <= (o_wb_addr << 8) | AW'(i_rx_tdata);
          cnt       <= last_a ? '0 : cnt + CW'(1);
        end
        DATA: begin
          o_wb_data <= (o_wb_data << 8) | DW'(i_rx_tdata);
          cnt       <= last_d ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // response bytes leave from the top of a shift register, MSB first
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_sr   <= '0;
      tx_left <= '0;
    end else if (ld_e) begin
      tx_sr   <= {ST_E, {(DW-8){1'b0}}};
      tx_left <= CW'(1);
    end else if (ld_t) begin
      tx_sr   <= {ST_T, {(DW-8){1'b0}}};
      tx_left <= CW'(1);
    end else if (ld_ack) begin
      if (o_wb_we) begin
        tx_sr   <= {ST_K, {(DW-8){1'b0}}};
        tx_left <= CW'(1);
      end else begin
        tx_sr   <= i_wb_data;
        tx_left <= CW'(DATA_BYTES);
      end
    end else if (tx_fire) begin
      tx_sr   <= tx_sr << 8;
      tx_left <= tx_left - CW'(1);
    end
  end

  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_count <= '0;
    end else if (err_inc && o_err_count != 8'hFF) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: vector table of frames plus directed sequences
// for timeouts, early acks, counter saturation and mid-transaction reset.
module tb_uart_wb_bridge;

  localparam int RX_TO  = 40;
  localparam int ACK_TO = 30;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_tdata;
  logic         rx_tvalid;
  logic         rx_tready;
  logic [7:0]   tx_tdata;
  logic         tx_tvalid;
  logic         tx_tready;
  logic         wb_cyc;
  logic         wb_stb;
  logic         wb_we;
  logic [23:0]  wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_sel;
  logic         wb_stall;
  logic         wb_ack;
  logic [127:0] wb_rdata;
  logic [7:0]   err_count;

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int cyc_cnt = 0;

  uart_wb_bridge #(
    .ADDR_BYTES (3),
    .DATA_BYTES (16),
    .RX_TIMEOUT (RX_TO),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .i_controller_clk(clk),
    .i_rst_n         (rst_n),
    .i_rx_tdata      (rx_tdata),
    .i_rx_tvalid     (rx_tvalid),
    .o_rx_tready     (rx_tready),
    .o_tx_tdata      (tx_tdata),
    .o_tx_tvalid     (tx_tvalid),
    .i_tx_tready     (tx_tready),
    .o_wb_cyc        (wb_cyc),
    .o_wb_stb        (wb_stb),
    .o_wb_we         (wb_we),
    .o_wb_addr       (wb_addr),
    .o_wb_data       (wb_data),
    .o_wb_sel        (wb_sel),
    .i_wb_stall      (wb_stall),
    .i_wb_ack        (wb_ack),
    .i_wb_data       (wb_rdata),
    .o_err_count     (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !wb_stall) acc_cnt++;
    if (wb_cyc) cyc_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]   op;
    logic [23:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           stall_cyc;
    int           ack_dly;
    int           gap;
    logic         exp_wb;
    int           ntx;
    logic [127:0] exp_tx;
    logic [7:0]   exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(
    input logic [7:0]   op,
    input logic [23:0]  addr,
    input logic [127:0] wdata,
    input logic [127:0] rdata,
    input int           stall_cyc,
    input int           ack_dly,
    input int           gap,
    input logic         exp_wb,
    input int           ntx,
    input logic [127:0] exp_tx,
    input logic [7:0]   exp_err
  );
    vec_t v;
    v.op        = op;
    v.addr      = addr;
    v.wdata     = wdata;
    v.rdata     = rdata;
    v.stall_cyc = stall_cyc;
    v.ack_dly   = ack_dly;
    v.gap       = gap;
    v.exp_wb    = exp_wb;
    v.ntx       = ntx;
    v.exp_tx    = exp_tx;
    v.exp_err   = exp_err;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // call right after a negedge; returns at the negedge after the
  // posedge that consumed the byte
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    while (!rx_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rx_tready wait", 128'(rx_tready), 128'd1);
    @(negedge clk);
    rx_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op,
                            input logic [23:0] addr,
                            input logic [127:0] wdata);
    send_byte(op);
    if (op == OP_W || op == OP_R)
      for (int i = 0; i < 3; i++) send_byte(addr[23-8*i -: 8]);
    if (op == OP_W)
      for (int i = 0; i < 16; i++) send_byte(wdata[127-8*i -: 8]);
  endtask

  task automatic recv(input vec_t v, input string tag);
    for (int i = 0; i < v.ntx; i++) begin
      tx_tready = 1'b0;
      for (int g = 0; g < v.gap; g++) begin
        chk($sformatf("%s tvalid hold b%0d", tag, i),
            128'(tx_tvalid), 128'd1);
        chk($sformatf("%s tdata hold b%0d", tag, i),
            128'(tx_tdata), 128'(v.exp_tx[127-8*i -: 8]));
        @(negedge clk);
      end
      chk($sformatf("%s tvalid b%0d", tag, i),
          128'(tx_tvalid), 128'd1);
      chk($sformatf("%s tdata b%0d", tag, i),
          128'(tx_tdata), 128'(v.exp_tx[127-8*i -: 8]));
      tx_tready = 1'b1;
      @(negedge clk);
      tx_tready = 1'b0;
    end
    chk($sformatf("%s tvalid end", tag), 128'(tx_tvalid), 128'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc0;
    int cyc0;
    acc0     = acc_cnt;
    cyc0     = cyc_cnt;
    wb_stall = (v.stall_cyc > 0);
    send_frame(v.op, v.addr, v.wdata);
    if (v.exp_wb) begin
      chk({tag, " stb latency"}, 128'(wb_stb), 128'd1);
      chk({tag, " addr"}, 128'(wb_addr), 128'(v.addr));
      chk({tag, " we"}, 128'(wb_we), 128'(v.op == OP_W));
      chk({tag, " sel"}, 128'(wb_sel), 128'hFFFF);
      if (v.op == OP_W) chk({tag, " wdata"}, wb_data, v.wdata);
      for (int i = 0; i < v.stall_cyc; i++) begin
        @(negedge clk);
        chk({tag, " stb stalled"}, 128'(wb_stb), 128'd1);
        chk({tag, " addr stalled"}, 128'(wb_addr), 128'(v.addr));
      end
      wb_stall = 1'b0;
      if (v.ack_dly == 0) begin
        wb_ack   = 1'b1;
        wb_rdata = v.rdata;
      end
      @(negedge clk);
      if (v.ack_dly == 0) begin
        wb_ack   = 1'b0;
        wb_rdata = '0;
      end else begin
        chk({tag, " stb drop"}, 128'(wb_stb), 128'd0);
        chk({tag, " cyc wait"}, 128'(wb_cyc), 128'd1);
        if (v.ack_dly > 0) begin
          repeat (v.ack_dly-1) @(negedge clk);
          chk({tag, " no early tx"}, 128'(tx_tvalid), 128'd0);
          wb_ack   = 1'b1;
          wb_rdata = v.rdata;
          @(negedge clk);
          wb_ack   = 1'b0;
          wb_rdata = '0;
        end else begin
          repeat (ACK_TO-1) @(negedge clk);
          chk({tag, " cyc before tmo"}, 128'(wb_cyc), 128'd1);
          @(negedge clk);
        end
      end
      chk({tag, " cyc low"}, 128'(wb_cyc), 128'd0);
      chk({tag, " accepts"}, 128'(acc_cnt - acc0), 128'd1);
    end else begin
      chk({tag, " no wb"}, 128'(cyc_cnt - cyc0), 128'd0);
    end
    recv(v, tag);
    chk({tag, " err"}, 128'(err_count), 128'(v.exp_err));
  endtask

  initial begin
    vec_t vx;
    rst_n     = 1'b1;
    rx_tdata  = '0;
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    wb_stall  = 1'b0;
    wb_ack    = 1'b0;
    wb_rdata  = '0;

    vecs[0] = mk(OP_W, 24'h000005,
                 128'h000102030405060708090A0B0C0D0E0F, '0,
                 0, 3, 0, 1'b1, 1, {8'h4B, 120'h0}, 8'd0);
    vecs[1] = mk(OP_R, 24'h000005, '0, {16{8'hA5}},
                 0, 2, 5, 1'b1, 16, {16{8'hA5}}, 8'd0);
    vecs[2] = mk(OP_W, 24'hABCDEF,
                 128'hFFEEDDCCBBAA99887766554433221100, '0,
                 7, 1, 1, 1'b1, 1, {8'h4B, 120'h0}, 8'd0);
    vecs[3] = mk(OP_R, 24'h123456, '0,
                 128'h00112233445566778899AABBCCDDEEFF,
                 0, 0, 0, 1'b1, 16,
                 128'h00112233445566778899AABBCCDDEEFF, 8'd0);
    vecs[4] = mk(8'h41, '0, '0, '0,
                 0, 0, 0, 1'b0, 1, {8'h45, 120'h0}, 8'd1);
    vecs[5] = mk(OP_W, 24'h000010, {8{16'h5AC3}}, '0,
                 0, -1, 2, 1'b1, 1, {8'h54, 120'h0}, 8'd2);
    vecs[6] = mk(OP_R, 24'hFFFFFF, '0,
                 128'hDEADBEEF0123456789ABCDEFCAFEF00D,
                 2, 4, 0, 1'b1, 16,
                 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 8'd2);

    #3 rst_n = 1'b0;
    #1;
    chk("rst rx_tready", 128'(rx_tready), 128'd1);
    chk("rst tx_tvalid", 128'(tx_tvalid), 128'd0);
    chk("rst tx_tdata", 128'(tx_tdata), 128'd0);
    chk("rst cyc", 128'(wb_cyc), 128'd0);
    chk("rst stb", 128'(wb_stb), 128'd0);
    chk("rst we", 128'(wb_we), 128'd0);
    chk("rst addr", 128'(wb_addr), 128'd0);
    chk("rst data", wb_data, 128'd0);
    chk("rst sel", 128'(wb_sel), 128'hFFFF);
    chk("rst err", 128'(err_count), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // ack while idle must not start a response
    wb_ack   = 1'b1;
    wb_rdata = {16{8'h11}};
    @(negedge clk);
    wb_ack   = 1'b0;
    wb_rdata = '0;
    @(negedge clk);
    chk("idle ack tvalid", 128'(tx_tvalid), 128'd0);
    chk("idle ack cyc", 128'(wb_cyc), 128'd0);

    // rx timeout, with a byte that restarts the timer first
    send_byte(OP_R);
    send_byte(8'h00);
    repeat (RX_TO-2) @(negedge clk);
    send_byte(8'h00);
    repeat (RX_TO-1) @(negedge clk);
    chk("rxto before", 128'(err_count), 128'd2);
    @(negedge clk);
    chk("rxto after", 128'(err_count), 128'd3);
    chk("rxto cyc", 128'(wb_cyc), 128'd0);
    run_vec(mk(OP_R, 24'h000102, '0, {8{16'h3C96}},
               0, 1, 0, 1'b1, 16, {8{16'h3C96}}, 8'd3),
            "post_rxto");

    // ack during a stalled request is ignored
    wb_stall = 1'b1;
    send_frame(OP_R, 24'h000042, '0);
    chk("early stb", 128'(wb_stb), 128'd1);
    wb_ack   = 1'b1;
    wb_rdata = {16{8'hEE}};
    @(negedge clk);
    wb_ack   = 1'b0;
    wb_rdata = '0;
    chk("early ack stb", 128'(wb_stb), 128'd1);
    chk("early ack tvalid", 128'(tx_tvalid), 128'd0);
    wb_stall = 1'b0;
    @(negedge clk);
    chk("early ack wait stb", 128'(wb_stb), 128'd0);
    chk("early ack wait cyc", 128'(wb_cyc), 128'd1);
    chk("early ack wait tv", 128'(tx_tvalid), 128'd0);
    @(negedge clk);
    wb_ack   = 1'b1;
    wb_rdata = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    @(negedge clk);
    wb_ack   = 1'b0;
    wb_rdata = '0;
    chk("early ack cyc low", 128'(wb_cyc), 128'd0);
    vx = mk(OP_R, 24'h000042, '0, '0, 0, 0, 0, 1'b1, 16,
            128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 8'd3);
    recv(vx, "early_ack");

    // err counter saturation
    tx_tready = 1'b1;
    for (int k = 0; k < 251; k++) begin
      send_byte(8'h00);
      @(negedge clk);
    end
    chk("err 254", 128'(err_count), 128'd254);
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h00);
      @(negedge clk);
    end
    chk("err saturate", 128'(err_count), 128'd255);
    tx_tready = 1'b0;

    // async reset while waiting for ack
    send_frame(OP_R, 24'h000007, '0);
    chk("rst seq stb", 128'(wb_stb), 128'd1);
    @(negedge clk);
    chk("rst seq wait cyc", 128'(wb_cyc), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst cyc", 128'(wb_cyc), 128'd0);
    chk("mid rst stb", 128'(wb_stb), 128'd0);
    chk("mid rst tvalid", 128'(tx_tvalid), 128'd0);
    chk("mid rst rx_tready", 128'(rx_tready), 128'd1);
    chk("mid rst err", 128'(err_count), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(mk(OP_R, 24'h000008, '0,
               128'h89ABCDEF0123456776543210FEDCBA98,
               1, 2, 1, 1'b1, 16,
               128'h89ABCDEF0123456776543210FEDCBA98, 8'd0),
            "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
